// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - request/response bundle for the multi-cycle shift sequencer
interface shift_seq_ctrl_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [1:0]  i_op;
    logic [31:0] i_operand_a;
    logic [4:0]  i_operand_b;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_busy;

    // Requester / result consumer side
    modport master (
        output i_req_valid,
        output i_op,
        output i_operand_a,
        output i_operand_b,
        output i_rsp_ready,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_data,
        input  o_busy
    );

    // Shift sequencer side
    modport slave (
        input  i_req_valid,
        input  i_op,
        input  i_operand_a,
        input  i_operand_b,
        input  i_rsp_ready,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_data,
        output o_busy
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - iterative SLL/SRL/SRA unit built on a narrow right-shift step
module shift_seq_ctrl #(
    parameter int MAX_STEP = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_flush,
    shift_seq_ctrl_if.slave bus
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [5:0] STEP_MAX = 6'(MAX_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] data_q;
    logic [4:0]  remaining_q;
    logic [1:0]  op_q;
    logic        sign_q;

    logic        accept;
    logic [5:0]  rem_ext;
    logic [5:0]  step;
    logic        last_step;
    logic [31:0] fill_mask;
    logic [31:0] shifted;

    // SLL is done as a right shift of the bit-reversed operand
    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    assign accept    = (state_q == ST_IDLE) && bus.i_req_valid && !i_flush;
    assign rem_ext   = {1'b0, remaining_q};
    assign step      = (rem_ext < STEP_MAX) ? rem_ext : STEP_MAX;
    assign last_step = (rem_ext == step);
    // step never exceeds 31 because remaining is a 5-bit count
    assign fill_mask = ~(32'hFFFF_FFFF >> step) & {32{sign_q}};
    assign shifted   = (data_q >> step) | fill_mask;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; flush overrides any normal transition
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_req_valid) begin
                        state_d = (bus.i_operand_b == 5'd0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_step) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.i_rsp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Operand capture on accept, one narrow shift step per SHIFT cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q      <= 32'd0;
            remaining_q <= 5'd0;
            op_q        <= 2'b00;
            sign_q      <= 1'b0;
        end else if (i_flush) begin
            remaining_q <= 5'd0;
        end else if (accept) begin
            op_q        <= bus.i_op;
            sign_q      <= (bus.i_op == OP_SRA) && bus.i_operand_a[31];
            remaining_q <= bus.i_operand_b;
            data_q      <= (bus.i_op == OP_SLL) ? bit_rev(bus.i_operand_a) : bus.i_operand_a;
        end else if (state_q == ST_SHIFT) begin
            data_q      <= shifted;
            remaining_q <= remaining_q - step[4:0];
        end
    end

    // Handshake and result outputs decoded from the current state
    always_comb begin
        bus.o_req_ready = (state_q == ST_IDLE) && i_rst_n;
        bus.o_rsp_valid = (state_q == ST_DONE);
        bus.o_busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        bus.o_rsp_data  = 32'd0;
        if (state_q == ST_DONE) begin
            bus.o_rsp_data = (op_q == OP_SLL) ? bit_rev(data_q) : data_q;
        end
    end

endmodule
